// File: rtl/key_rom_loader.sv
// key_rom_loader: streams a runtime-length key from a latency-L synchronous ROM into a register array.
// Define KEY_ROM_LOADER_CHECKSUM_EN to add an XOR checksum of the captured bytes on key_sum_o.
module key_rom_loader #(
  parameter int MAX_KEY_LENGTH = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int BASE_ADDR      = 0
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       start_i,
  input  logic                                       abort_i,
  input  logic [ADDR_WIDTH:0]                        key_len_i,
  input  logic                                       reverse_i,
  input  logic [DATA_WIDTH-1:0]                      rom_q_i,
  output logic [ADDR_WIDTH-1:0]                      rom_addr_o,
  output logic                                       rom_rd_o,
  output logic [MAX_KEY_LENGTH-1:0][DATA_WIDTH-1:0]  key_arr_o,
  output logic                                       busy_o,
  output logic                                       finished_o,
  output logic                                       done_pulse_o,
  output logic [1:0]                                 state_tap_o,
  output logic [DATA_WIDTH-1:0]                      key_sum_o
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int RL = READ_LATENCY;
  localparam logic [CW-1:0] MAXL = CW'(MAX_KEY_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIN = 2'b10} state_t;
  state_t state_q, state_d;
  logic start_q, rev_q, rev_d, rd_q, rd_d, done_q, done_d;
  logic [CW-1:0] len_q, len_d, cnt_q, cnt_d, klen, cidx, widx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MAX_KEY_LENGTH-1:0][DATA_WIDTH-1:0] key_q, key_d;
  logic [RL-1:0] vld_q, vld_d;
  logic [RL-1:0][CW-1:0] idx_q, idx_d;
  logic go, cap, last;
  assign go   = start_i & ~start_q & (state_q == IDLE || state_q == FIN);
  assign klen = key_len_i > MAXL ? MAXL : key_len_i;
  assign cap  = state_q == RUN && vld_q[RL-1] && !abort_i;
  assign cidx = idx_q[RL-1];
  assign widx = rev_q ? len_q - cidx - 1'b1 : cidx;
  assign last = cidx == len_q - 1'b1;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rev_d   = rev_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    key_d   = key_q;
    done_d  = 1'b0;
    vld_d[0] = rd_q;
    idx_d[0] = cnt_q;
    for (int k = 1; k < RL; k++) begin
      vld_d[k] = vld_q[k-1];
      idx_d[k] = idx_q[k-1];
    end
    if (go) begin
      key_d   = '0;
      len_d   = klen;
      rev_d   = reverse_i;
      cnt_d   = '0;
      addr_d  = BASE;
      rd_d    = klen != '0;
      state_d = klen != '0 ? RUN : FIN;
      done_d  = klen == '0;
    end else if (state_q == RUN) begin
      if (abort_i) begin
        state_d = IDLE;
        key_d   = '0;
        vld_d   = '0;
      end else begin
        if (rd_q) begin
          rd_d   = cnt_q != len_q - 1'b1;
          cnt_d  = cnt_q + CW'(rd_d);
          addr_d = BASE + ADDR_WIDTH'(cnt_d);
        end
        for (int j = 0; j < MAX_KEY_LENGTH; j++)
          if (cap && widx == CW'(j)) key_d[j] = rom_q_i;
        if (cap && last) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
    end else if (state_q != FIN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      len_q   <= '0;
      rev_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      key_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      len_q   <= len_d;
      rev_q   <= rev_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      key_q   <= key_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) sum_q <= '0;
    else if (go || (state_q == RUN && abort_i)) sum_q <= '0;
    else if (cap) sum_q <= sum_q ^ rom_q_i;
  assign key_sum_o = sum_q;
`else
  assign key_sum_o = '0;
`endif
  assign rom_addr_o   = addr_q;
  assign rom_rd_o     = rd_q;
  assign key_arr_o    = key_q;
  assign busy_o       = state_q == RUN;
  assign finished_o   = state_q == FIN;
  assign done_pulse_o = done_q;
  assign state_tap_o  = state_q;
endmodule

// File: tb/tb_key_rom_loader.sv
// tb_key_rom_loader: drives a latency-1 and a latency-3 loader side by side from behavioural ROMs.
module tb_key_rom_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, reverse = 1'b0;
  logic [5:0] key_len = '0;
  logic [7:0] mem [32];
  logic [7:0] rq0, s1, s2, s3;
  logic [4:0] addr0, addr3;
  logic rd0, rd3, busy0, busy3, fin0, fin3, dp0, dp3;
  logic [31:0][7:0] key0, key3;
  logic [1:0] st0, st3;
  logic [7:0] sum0, sum3;
  int n_cmp = 0, n_bad = 0;
  int fk0, fk3, np0, np3;
  logic b0, b3, ab_ok;
  typedef struct {
    logic [5:0] len;
    logic       rev;
    logic [7:0] off;
    int         elen;
    int         f1;
    int         f3;
  } vec_t;
  vec_t tv [7];
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    rq0 <= mem[addr0];
    s1  <= mem[addr3];
    s2  <= s1;
    s3  <= s2;
  end
  key_rom_loader #(.READ_LATENCY(1)) u0 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .key_len_i(key_len),
    .reverse_i(reverse), .rom_q_i(rq0), .rom_addr_o(addr0), .rom_rd_o(rd0), .key_arr_o(key0),
    .busy_o(busy0), .finished_o(fin0), .done_pulse_o(dp0), .state_tap_o(st0), .key_sum_o(sum0));
  key_rom_loader #(.READ_LATENCY(3)) u3 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .key_len_i(key_len),
    .reverse_i(reverse), .rom_q_i(s3), .rom_addr_o(addr3), .rom_rd_o(rd3), .key_arr_o(key3),
    .busy_o(busy3), .finished_o(fin3), .done_pulse_o(dp3), .state_tap_o(st3), .key_sum_o(sum3));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_key(input string nm, input logic [31:0][7:0] act, input logic [31:0][7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0][7:0] expk(input logic rev, input int n, input logic [7:0] off);
    logic [31:0][7:0] r = '0;
    for (int j = 0; j < n; j++) r[j] = rev ? off + 8'(n - 1 - j) : off + 8'(j);
    return r;
  endfunction
  function automatic logic [7:0] exps(input logic [31:0][7:0] k);
    logic [7:0] s = '0;
`ifdef KEY_ROM_LOADER_CHECKSUM_EN
    for (int j = 0; j < 32; j++) s = s ^ k[j];
`endif
    return s;
  endfunction
  task automatic fill(input logic [7:0] off);
    for (int i = 0; i < 32; i++) mem[i] = off + 8'(i);
  endtask
  task automatic run_load(input logic [5:0] len, input logic rev, input bit rep, input int ab);
    @(negedge clk);
    key_len = len;
    reverse = rev;
    start = 1'b1;
    @(posedge clk);
    fk0 = 0; fk3 = 0; np0 = 0; np3 = 0; b0 = 0; b3 = 0; ab_ok = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) begin b0 = busy0; b3 = busy3; end
      if (fin0 && fk0 == 0) fk0 = k;
      if (fin3 && fk3 == 0) fk3 = k;
      if (dp0) np0++;
      if (dp3) np3++;
      if (ab != 0 && k == ab + 1)
        ab_ok = st0 == 2'b00 && !rd0 && key0 == '0 && !busy0 && st3 == 2'b00 && !rd3 && key3 == '0 && !busy3;
      start = rep && k == 5;
      abort = ab == k;
    end
  endtask
  task automatic run_vec(input int i);
    logic [31:0][7:0] ek;
    fill(tv[i].off);
    run_load(tv[i].len, tv[i].rev, 1'b0, 0);
    ek = expk(tv[i].rev, tv[i].elen, tv[i].off);
    chk($sformatf("v%0d fin_cycle_l1", i), 64'(fk0), 64'(tv[i].f1));
    chk($sformatf("v%0d fin_cycle_l3", i), 64'(fk3), 64'(tv[i].f3));
    chk($sformatf("v%0d pulses_l1", i), 64'(np0), 64'd1);
    chk($sformatf("v%0d pulses_l3", i), 64'(np3), 64'd1);
    chk($sformatf("v%0d busy_l1", i), 64'(b0), 64'(tv[i].elen != 0));
    chk($sformatf("v%0d busy_l3", i), 64'(b3), 64'(tv[i].elen != 0));
    chk_key($sformatf("v%0d key_l1", i), key0, ek);
    chk_key($sformatf("v%0d key_l3", i), key3, ek);
    chk($sformatf("v%0d sum_l1", i), 64'(sum0), 64'(exps(ek)));
    chk($sformatf("v%0d sum_l3", i), 64'(sum3), 64'(exps(ek)));
  endtask
  initial begin
    tv[0] = '{6'd32, 1'b0, 8'h01, 32, 34, 36};
    tv[1] = '{6'd5,  1'b1, 8'hA0, 5,  7,  9};
    tv[2] = '{6'd0,  1'b0, 8'h33, 0,  1,  1};
    tv[3] = '{6'd40, 1'b0, 8'h10, 32, 34, 36};
    tv[4] = '{6'd4,  1'b0, 8'h00, 4,  6,  8};
    tv[5] = '{6'd3,  1'b0, 8'h00, 3,  5,  7};
    tv[6] = '{6'd1,  1'b1, 8'h55, 1,  3,  5};
    fill(8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst state", 64'({st0, st3}), 64'd0);
    chk("rst rd/busy/fin/dp", 64'({rd0, busy0, fin0, dp0, rd3, busy3, fin3, dp3}), 64'd0);
    chk("rst addr", 64'({addr0, addr3}), 64'd0);
    chk_key("rst key", key0 | key3, '0);
    chk("rst sum", 64'({sum0, sum3}), 64'd0);
    for (int i = 0; i < 7; i++) run_vec(i);
    fill(8'h01);
    run_load(6'd32, 1'b0, 1'b0, 4);
    chk("abort snapshot", 64'(ab_ok), 64'd1);
    chk("abort pulses", 64'({np0, np3}), 64'd0);
    chk("abort fin", 64'({fin0, fin3}), 64'd0);
    chk("abort sum", 64'({sum0, sum3}), 64'd0);
    run_vec(0);
    fill(8'h01);
    run_load(6'd32, 1'b0, 1'b1, 0);
    chk("repulse pulses", 64'({np0, np3}), {32'd1, 32'd1});
    chk("repulse fin_cycle", 64'({fk0, fk3}), {32'd34, 32'd36});
    chk_key("repulse key", key0, expk(1'b0, 32, 8'h01));
    @(negedge clk);
    key_len = 6'd32;
    reverse = 1'b0;
    start = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    start = 1'b0;
    chk("pre-reset busy", 64'({busy0, busy3}), 64'h3);
    #2 reset = 1'b1;
    #1;
    chk("areset state", 64'({st0, st3}), 64'd0);
    chk("areset rd/busy/fin/dp", 64'({rd0, busy0, fin0, dp0, rd3, busy3, fin3, dp3}), 64'd0);
    chk("areset addr", 64'({addr0, addr3}), 64'd0);
    chk_key("areset key", key0 | key3, '0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/key_rom_loader.md
Name: key_rom_loader

Overview:
Parametrised successor to the single-key ROM loader. It streams a runtime-selectable number of key bytes from a synchronous ROM with configurable read latency into a register array. Entries may be stored in forward or reversed order, and a load can be aborted. It sits between the key ROM and the RC4 KSA/PRGA datapath, and reloads on every start edge.

Parameters:
MAX_KEY_LENGTH, 32, key array entries; upper bound on the runtime length.
ADDR_WIDTH, 5, ROM address width; 2**ADDR_WIDTH >= BASE_ADDR+MAX_KEY_LENGTH.
DATA_WIDTH, 8, ROM word and key-entry width.
READ_LATENCY, 1, ROM cycles from address to data; legal range 1..4.
BASE_ADDR, 0, ROM address of key byte 0.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  level input; a rising edge (start high, registered start_q low) requests a load
abort  in  1  synchronous; cancels a load in progress
key_len  in  ADDR_WIDTH+1  bytes to load; sampled on the accepted start edge
reverse  in  1  store order select; sampled on the accepted start edge
rom_q  in  DATA_WIDTH  ROM read data
rom_addr  out  ADDR_WIDTH  registered ROM address
rom_rd  out  1  high while an address is being issued
key_arr  out  MAX_KEY_LENGTH x DATA_WIDTH  loaded key, packed array
busy  out  1  state == RUN
finished  out  1  level; key_arr complete
done_pulse  out  1  one cycle high on entry to FINISHED
state_tap  out  2  encoded state, for debug

Behaviour:
- Reset (async, active-high): state IDLE. start_q, rom_addr, rom_rd, key_arr, busy, finished, done_pulse, issue/capture counters and the valid delay line all go to 0.
- States and encodings: IDLE=00, RUN=01, FINISHED=10. 11 is unused and recovers to IDLE.
- IDLE/FINISHED -> RUN on an accepted start edge, if the latched length is nonzero. On that clock edge:
  - key_arr is cleared to 0.
  - len_q = min(key_len, MAX_KEY_LENGTH); rev_q = reverse.
  - issue_cnt = 0; rom_addr = BASE_ADDR; rom_rd = 1.
- Latched length of 0: the next state is FINISHED directly, key_arr is cleared, and done_pulse fires for one cycle.
- Issue phase (RUN):
  - rom_addr = BASE_ADDR + issue_cnt, one address per cycle.
  - After the address for issue_cnt = len_q-1, rom_rd drops to 0.
- Capture timing:
  - Data for the address presented in cycle c is valid on rom_q during cycle c+READ_LATENCY.
  - It is written at the clock edge closing that cycle, tracked by a READ_LATENCY-deep valid/index shift line.
- Store index: forward mode writes byte i to key_arr[i]; reverse mode writes it to key_arr[len_q-1-i]. Entries at index len_q and above stay 0.
- Latency: start edge sampled at the end of cycle T. Then:
  - RUN begins in T+1.
  - The last address is issued in T+len_q.
  - The last capture happens at the end of T+len_q+READ_LATENCY.
  - finished=1 and done_pulse=1 in cycle T+len_q+READ_LATENCY+1.
- RUN -> FINISHED after the final capture. finished stays high until the next accepted start or reset.
- A start edge during RUN is ignored and not queued.
- abort during RUN (abort has priority over capture):
  - The next state is IDLE and key_arr is cleared.
  - The valid line is flushed; rom_rd is 0 next cycle.
  - No done_pulse is produced.
- abort outside RUN has no effect.
- Start edge and abort in the same IDLE/FINISHED cycle: the start is accepted.
- An async reset asserted mid-load aborts immediately. No partial key remains.
- issue_cnt and the index arithmetic are ADDR_WIDTH+1 bits wide, with no wrap inside a load. The BASE_ADDR+issue_cnt sum is truncated to ADDR_WIDTH.

Optional Feature:
KEY_ROM_LOADER_CHECKSUM_EN
- Defined: adds output key_sum[DATA_WIDTH-1:0]. It is the XOR of all captured bytes, cleared on an accepted start or abort, reset to 0, and valid whenever finished=1.
- Undefined: the key_sum port still exists but is tied to 0, and no checksum logic is synthesised.

Test Plan:
- Forward load, defaults, ROM[i]=i+1, key_len=32, start edge at end of T=0 -> finished and done_pulse in cycle 34; key_arr[i]=i+1; done_pulse low in cycle 35.
- READ_LATENCY=3, key_len=5, reverse=1, ROM[i]=8'hA0+i -> key_arr[0..4]=A4,A3,A2,A1,A0; key_arr[5..31]=0; finished in cycle T+9.
- key_len=0 -> FINISHED one cycle after the edge; key_arr all 0; single done_pulse. key_len=40 -> clamped to 32.
- abort asserted 4 cycles into a 32-byte load -> IDLE next cycle; key_arr=0; no done_pulse; a following start reloads correctly.
- Start re-pulsed during RUN -> ignored, single completion. Async reset mid-load -> all outputs 0 immediately; state_tap=00.
- CHECKSUM_EN with ROM[i]=i, key_len=4 -> key_sum=8'h00 (0^1^2^3). With key_len=3 -> key_sum=8'h03.
